// File: rtl/display_decimal_seq.sv
// Sequential binary-to-7-segment driver: double-dabble conversion, one bit per clock.
// Optional macro DISPLAY_SUPRESSAO_ZEROS_EN blanks leading zero digits (units always shown).
module display_decimal_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 4,
    parameter int SIGNED     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] valor,
    output logic                  busy,
    output logic                  pronto,
    output logic                  overflow,
    output logic                  saida_sinal,
    output logic [7*DIGITS-1:0]   segmentos
);

    localparam int NIB = (DATA_WIDTH * 302 + 999) / 1000 + 1;
    localparam int EXT = (NIB > DIGITS) ? NIB : DIGITS;
    localparam int CW  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] val_reg;
    logic [DATA_WIDTH-1:0] mag;
    logic [4*NIB-1:0]      bcd;
    logic [4*NIB-1:0]      bcd_adj;
    logic [CW-1:0]         bit_cnt;
    logic                  sign;
    logic                  in_neg;
    logic [4*EXT-1:0]      bcd_ext;
    logic [7*DIGITS-1:0]   seg_next;
    logic                  ovf_next;
`ifdef DISPLAY_SUPRESSAO_ZEROS_EN
    logic                  lead_seen;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (bit_cnt == CW'(1)) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign in_neg = (SIGNED != 0) && val_reg[DATA_WIDTH-1];

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NIB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digits above the internal BCD width (DIGITS > NIB) read as zero.
    always_comb begin
        bcd_ext            = '0;
        bcd_ext[4*NIB-1:0] = bcd;
        ovf_next           = 1'b0;
        for (int i = 0; i < EXT; i++) begin
            if (i >= DIGITS && bcd_ext[4*i +: 4] != 4'd0) ovf_next = 1'b1;
        end
        seg_next = '1;
`ifdef DISPLAY_SUPRESSAO_ZEROS_EN
        lead_seen = 1'b0;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_next) begin
                seg_next[7*i +: 7] = 7'b1111110;
            end else begin
`ifdef DISPLAY_SUPRESSAO_ZEROS_EN
                if (bcd_ext[4*i +: 4] != 4'd0) lead_seen = 1'b1;
                if (lead_seen || i == 0) seg_next[7*i +: 7] = seg_of(bcd_ext[4*i +: 4]);
                else                     seg_next[7*i +: 7] = 7'b1111111;
`else
                seg_next[7*i +: 7] = seg_of(bcd_ext[4*i +: 4]);
`endif
            end
        end
    end

    // valor is latched with start so it may change freely during the conversion.
    always_ff @(posedge clock) begin
        if (reset) begin
            val_reg     <= '0;
            mag         <= '0;
            bcd         <= '0;
            bit_cnt     <= '0;
            sign        <= 1'b0;
            busy        <= 1'b0;
            pronto      <= 1'b0;
            overflow    <= 1'b0;
            saida_sinal <= 1'b0;
            segmentos   <= '1;
        end else begin
            pronto <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) val_reg <= valor;
                end
                LOAD: begin
                    sign    <= in_neg;
                    mag     <= in_neg ? (~val_reg + DATA_WIDTH'(1)) : val_reg;
                    bcd     <= '0;
                    bit_cnt <= CW'(DATA_WIDTH);
                    busy    <= 1'b1;
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj[4*NIB-2:0], mag, 1'b0};
                    bit_cnt    <= bit_cnt - CW'(1);
                end
                UPDATE: begin
                    segmentos   <= seg_next;
                    overflow    <= ovf_next;
                    saida_sinal <= sign;
                    busy        <= 1'b0;
                    pronto      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
